serial_mux: RTL and testbench
=============================

# serial_mux

Eight-channel packetizing multiplexer that feeds the serial demultiplexer's input bus. Each channel buffers bytes in a small FIFO; an arbiter selects a non-empty channel and emits a packet on the shared 8-bit bus. Each packet is a header byte {channel, count} flagged by `NewPacket`, followed by `count` payload bytes. The output is wire-compatible with the demux's `DataIn`/`NewPacket` pair.

## Interface
- `FIFO_DEPTH`, 4: per-channel FIFO depth; power of two, 2..8.
- `MAX_LEN`, 15: max payload bytes per packet; 1..15.

- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-high reset
- `DataIn0`..`DataIn7`  in  8 each  channel write data
- `Wr`  in  8  per-channel write strobe; bit i writes `DataIn`i
- `Full`  out  8  bit i high when FIFO i holds `FIFO_DEPTH` bytes
- `DataOut`  out  8  serial bus byte (registered)
- `NewPacket`  out  1  high with header byte only (registered)
- `Busy`  out  1  high whenever `DataOut` carries a header or payload byte (registered)

## Operation
- Reset values:
  - FIFOs empty; `Full`=0.
  - `DataOut`=0, `NewPacket`=0, `Busy`=0.
  - FSM=IDLE; round-robin pointer `last`=7.
- Write rules:
  - `Wr[i]`=1 with FIFO i not full pushes `DataIn`i.
  - Write when full is dropped; FIFO contents are unchanged.
  - Writes on all 8 channels in the same cycle are legal.
- FSM states: IDLE, PAYLOAD.
- IDLE:
  - Outputs driven to 0/0/0.
  - If any FIFO is non-empty, select channel c: first non-empty channel scanning from `last`+1 upward, mod 8.
  - Latch n = min(occupancy(c), `MAX_LEN`).
  - Register `DataOut`={1'b0,c[2:0],n[3:0]}, `NewPacket`=1, `Busy`=1; set `last`=c, remaining=n; go PAYLOAD.
- PAYLOAD:
  - Each cycle pop FIFO c and register the byte to `DataOut`, with `NewPacket`=0, `Busy`=1; decrement remaining.
  - After the pop with remaining=1, go IDLE.
- Count rules:
  - n ≥ 1 always; zero-length packets are never sent.
  - Bytes written to c while its packet is in flight are not added to n; they go in a later packet.
- Simultaneous push and pop on the same FIFO is legal; occupancy is unchanged.
- `Full[i]` is combinational from the occupancy counter and deasserts the cycle after a pop frees space.
- Occupancy counter width is clog2(`FIFO_DEPTH`)+1; pointers wrap mod `FIFO_DEPTH`.

## Timing
- A write sampled at edge k is visible to the arbiter at edge k+1.
- Earliest header appears after edge k+1; payload bytes appear after edges k+2 .. k+1+n.
- One IDLE cycle (`DataOut`=0, `Busy`=0) always separates consecutive packets.
- Packet length on the bus is n+1 cycles.
- Asserting `rst` mid-packet:
  - All outputs go to 0 immediately.
  - Buffered data is discarded.
  - FSM returns to IDLE and `last`=7.
  - First packet after reset is served from channel 0 upward.

## Configuration
- `SERIAL_MUX_FIXED_PRIORITY_EN` defined: the arbiter always selects the lowest-numbered non-empty channel and ignores `last`.
- Undefined (default): round-robin as described in Operation.
- Ports and timing are identical in both builds.

## Test plan
- Reset, then write 0x11, 0x22, 0x33 to channel 7 on consecutive cycles:
  - The arbiter samples while the FIFO is still filling, so the first packet is header 0x71 (count 1) with `NewPacket`=1, then 0x11.
  - After one idle cycle, header 0x72 then 0x22, 0x33.
  - Check `Busy` matches each packet span.
- Preload channel 0 with 0x88, 0x99 and channel 3 with 0xAA in the same cycles:
  - Round-robin gives header 0x02, 0x88, 0x99, then idle, then header 0x31, 0xAA.
  - Rerun with `SERIAL_MUX_FIXED_PRIORITY_EN`: same order.
- Keep channels 1 and 2 continuously non-empty:
  - Packets alternate 1,2,1,2 in round-robin.
  - With the macro, channel 1 is served exclusively while it stays non-empty.
- Write 6 bytes to channel 5 with `FIFO_DEPTH`=4:
  - `Full[5]` rises after the 4th write; bytes 5 and 6 are dropped.
  - Packet is header 0x54 plus the first 4 bytes.
- Write channel 4 during its own payload:
  - Header count excludes the new byte.
  - The new byte is sent in the next channel-4 packet as header 0x41.
- Assert `rst` during the second payload byte:
  - `DataOut`/`NewPacket`/`Busy` go to 0 asynchronously and `Full`=0.
  - After release, nothing is emitted until new writes arrive.

Source files
------------

// File: rtl/serial_mux.sv
// Eight-channel packetizing multiplexer: per-channel byte FIFOs drained as {channel,count} packets onto one bus.
// Define SERIAL_MUX_FIXED_PRIORITY_EN to make the arbiter always pick the lowest-numbered non-empty channel.
module serial_mux #(
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_LEN    = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] DataIn0,
    input  logic [7:0] DataIn1,
    input  logic [7:0] DataIn2,
    input  logic [7:0] DataIn3,
    input  logic [7:0] DataIn4,
    input  logic [7:0] DataIn5,
    input  logic [7:0] DataIn6,
    input  logic [7:0] DataIn7,
    input  logic [7:0] Wr,
    output logic [7:0] Full,
    output logic [7:0] DataOut,
    output logic       NewPacket,
    output logic       Busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {IDLE, PAYLOAD} state_t;

    state_t          state, stateNext;
    logic [7:0]      dataIn [8];
    logic [7:0]      mem [8][FIFO_DEPTH];
    logic [AW-1:0]   wrPtr [8];
    logic [AW-1:0]   rdPtr [8];
    logic [CW-1:0]   occ [8];
    logic [7:0]      push, pop, notEmpty;
    logic [2:0]      last, lastNext, chan, chanNext, pick;
    logic [3:0]      remaining, remainingNext, occSel, nSel;
    logic            anyReady;
    logic [7:0]      dataOutNext;
    logic            newPacketNext, busyNext;

    assign dataIn = '{DataIn0, DataIn1, DataIn2, DataIn3, DataIn4, DataIn5, DataIn6, DataIn7};

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            Full[i]     = (occ[i] == CW'(FIFO_DEPTH));
            notEmpty[i] = (occ[i] != '0);
            push[i]     = Wr[i] & ~Full[i];
            pop[i]      = (state == PAYLOAD) && (chan == 3'(i));
        end
    end

    // Pointers wrap naturally because the depth is a power of two
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                wrPtr[i] <= '0;
                rdPtr[i] <= '0;
                occ[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (push[i]) wrPtr[i] <= wrPtr[i] + AW'(1);
                if (pop[i])  rdPtr[i] <= rdPtr[i] + AW'(1);
                if (push[i] && !pop[i])      occ[i] <= occ[i] + CW'(1);
                else if (pop[i] && !push[i]) occ[i] <= occ[i] - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 8; i++) begin
            if (push[i]) mem[i][wrPtr[i]] <= dataIn[i];
        end
    end

    always_comb begin
        pick     = '0;
        anyReady = 1'b0;
`ifdef SERIAL_MUX_FIXED_PRIORITY_EN
        for (int k = 7; k >= 0; k--) begin
            if (notEmpty[k]) begin
                pick     = 3'(k);
                anyReady = 1'b1;
            end
        end
`else
        // Scan farthest-first so the channel nearest after last wins
        begin
            logic [2:0] idx;
            idx = '0;
            for (int k = 8; k >= 1; k--) begin
                idx = last + 3'(k);
                if (notEmpty[idx]) begin
                    pick     = idx;
                    anyReady = 1'b1;
                end
            end
        end
`endif
        occSel = 4'(occ[pick]);
        nSel   = (occSel > 4'(MAX_LEN)) ? 4'(MAX_LEN) : occSel;
    end

    // Busy still high in IDLE means a packet just ended, so hold one gap cycle
    always_comb begin
        stateNext     = state;
        lastNext      = last;
        chanNext      = chan;
        remainingNext = remaining;
        dataOutNext   = '0;
        newPacketNext = 1'b0;
        busyNext      = 1'b0;
        case (state)
            IDLE: begin
                if (!Busy && anyReady) begin
                    dataOutNext   = {1'b0, pick, nSel};
                    newPacketNext = 1'b1;
                    busyNext      = 1'b1;
                    lastNext      = pick;
                    chanNext      = pick;
                    remainingNext = nSel;
                    stateNext     = PAYLOAD;
                end
            end
            PAYLOAD: begin
                dataOutNext   = mem[chan][rdPtr[chan]];
                busyNext      = 1'b1;
                remainingNext = remaining - 4'd1;
                if (remaining == 4'd1) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            last      <= 3'd7;
            chan      <= '0;
            remaining <= '0;
            DataOut   <= '0;
            NewPacket <= 1'b0;
            Busy      <= 1'b0;
        end else begin
            state     <= stateNext;
            last      <= lastNext;
            chan      <= chanNext;
            remaining <= remainingNext;
            DataOut   <= dataOutNext;
            NewPacket <= newPacketNext;
            Busy      <= busyNext;
        end
    end

endmodule

// File: tb/tb_serial_mux.sv
// Self-checking bench for serial_mux: directed packet scenarios plus random traffic against a queue-based model.
module tb_serial_mux;

    localparam int DEPTH  = 4;
    localparam int MAXLEN = 15;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din [8];
    logic [7:0] wr;
    logic [7:0] Full, DataOut;
    logic       NewPacket, Busy;

    int errors = 0;
    int checks = 0;

    logic [7:0] q [8][$];
    int         mLast, mChan, mPending;
    bit         mGap;
    logic [7:0] expData;
    logic       expNew, expBusy;

    serial_mux #(.FIFO_DEPTH(DEPTH), .MAX_LEN(MAXLEN)) dut (
        .clk(clk), .rst(rst),
        .DataIn0(din[0]), .DataIn1(din[1]), .DataIn2(din[2]), .DataIn3(din[3]),
        .DataIn4(din[4]), .DataIn5(din[5]), .DataIn6(din[6]), .DataIn7(din[7]),
        .Wr(wr), .Full(Full), .DataOut(DataOut), .NewPacket(NewPacket), .Busy(Busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] expFull();
        logic [7:0] f;
        f = '0;
        for (int i = 0; i < 8; i++) f[i] = (q[i].size() >= DEPTH);
        return f;
    endfunction

    function automatic bit modelQuiet();
        bit quiet;
        quiet = (mPending == 0) && !mGap && !expBusy;
        for (int i = 0; i < 8; i++) if (q[i].size() != 0) quiet = 0;
        return quiet;
    endfunction

    function automatic void modelReset();
        for (int i = 0; i < 8; i++) q[i].delete();
        mLast = 7; mChan = 0; mPending = 0; mGap = 0;
        expData = '0; expNew = 1'b0; expBusy = 1'b0;
    endfunction

    // One bus slot: finish the current packet, else honour the gap, else open a new packet
    function automatic void modelEdge();
        logic [7:0] fullBefore;
        int c, n;
        logic [2:0] cc;
        logic [3:0] nn;
        fullBefore = expFull();
        expData = '0; expNew = 1'b0; expBusy = 1'b0;
        if (mPending > 0) begin
            if (q[mChan].size() > 0) expData = q[mChan].pop_front();
            expBusy = 1'b1;
            mPending--;
            if (mPending == 0) mGap = 1;
        end else if (mGap) begin
            mGap = 0;
        end else begin
            c = -1;
`ifdef SERIAL_MUX_FIXED_PRIORITY_EN
            for (int k = 0; k < 8; k++) if (c < 0 && q[k].size() > 0) c = k;
`else
            for (int k = 1; k <= 8; k++) if (c < 0 && q[(mLast + k) % 8].size() > 0) c = (mLast + k) % 8;
`endif
            if (c >= 0) begin
                n  = (q[c].size() < MAXLEN) ? q[c].size() : MAXLEN;
                cc = 3'(c);
                nn = 4'(n);
                expData = {1'b0, cc, nn};
                expNew = 1'b1; expBusy = 1'b1;
                mLast = c; mChan = c; mPending = n;
            end
        end
        for (int i = 0; i < 8; i++) if (wr[i] && !fullBefore[i]) q[i].push_back(din[i]);
    endfunction

    task automatic step();
        @(posedge clk);
        if (rst) modelReset();
        else modelEdge();
        #1;
    endtask

    task automatic clearInputs();
        wr = '0;
        for (int i = 0; i < 8; i++) din[i] = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clearInputs();
        modelReset();
        step();
        checks++;
        if ({DataOut, NewPacket, Busy, Full} !== 18'h0) begin
            errors++;
            $display("[TB] FAIL reset_hold: got data=%h np=%b busy=%b full=%b, want all zero", DataOut, NewPacket, Busy, Full);
        end
        rst = 1'b0;
        step();
        checks++;
        if ({DataOut, NewPacket, Busy, Full} !== 18'h0) begin
            errors++;
            $display("[TB] FAIL reset_release: got data=%h np=%b busy=%b full=%b, want all zero", DataOut, NewPacket, Busy, Full);
        end
    endtask

    task automatic test_channel7();
        logic [9:0] tbl [8];
        logic [7:0] bytes [3];
        tbl   = '{{8'h00, 2'b00}, {8'h71, 2'b11}, {8'h11, 2'b01}, {8'h00, 2'b00},
                  {8'h72, 2'b11}, {8'h22, 2'b01}, {8'h33, 2'b01}, {8'h00, 2'b00}};
        bytes = '{8'h11, 8'h22, 8'h33};
        for (int s = 0; s < 8; s++) begin
            clearInputs();
            if (s < 3) begin wr[7] = 1'b1; din[7] = bytes[s]; end
            step();
            checks++;
            if ({DataOut, NewPacket, Busy} !== tbl[s]) begin
                errors++;
                $display("[TB] FAIL ch7_slot%0d: got data=%h np=%b busy=%b, want %h/%b/%b", s, DataOut, NewPacket, Busy, tbl[s][9:2], tbl[s][1], tbl[s][0]);
            end
        end
    endtask

    task automatic test_roundrobin();
        logic [9:0] tbl [11];
        tbl = '{{8'h00, 2'b00}, {8'h61, 2'b11}, {8'h66, 2'b01}, {8'h00, 2'b00},
                {8'h02, 2'b11}, {8'h88, 2'b01}, {8'h99, 2'b01}, {8'h00, 2'b00},
                {8'h31, 2'b11}, {8'hAA, 2'b01}, {8'h00, 2'b00}};
        for (int s = 0; s < 11; s++) begin
            clearInputs();
            if (s == 0) begin wr[6] = 1'b1; din[6] = 8'h66; end
            if (s == 1) begin wr[0] = 1'b1; din[0] = 8'h88; wr[3] = 1'b1; din[3] = 8'hAA; end
            if (s == 2) begin wr[0] = 1'b1; din[0] = 8'h99; end
            step();
            checks++;
            if ({DataOut, NewPacket, Busy} !== tbl[s]) begin
                errors++;
                $display("[TB] FAIL order_slot%0d: got data=%h np=%b busy=%b, want %h/%b/%b", s, DataOut, NewPacket, Busy, tbl[s][9:2], tbl[s][1], tbl[s][0]);
            end
        end
    endtask

    task automatic test_full();
        logic [10:0] tbl [11];
        tbl = '{{8'h00, 3'b000}, {8'h41, 3'b110}, {8'h44, 3'b010}, {8'h00, 3'b001},
                {8'h54, 3'b111}, {8'hA1, 3'b010}, {8'hA2, 3'b010}, {8'hA3, 3'b010},
                {8'hA4, 3'b010}, {8'h00, 3'b000}, {8'h00, 3'b000}};
        for (int s = 0; s < 11; s++) begin
            clearInputs();
            if (s == 0) begin wr[4] = 1'b1; din[4] = 8'h44; end
            if (s < 6) begin wr[5] = 1'b1; din[5] = 8'hA1 + 8'(s); end
            step();
            checks++;
            if ({DataOut, NewPacket, Busy, Full[5]} !== tbl[s]) begin
                errors++;
                $display("[TB] FAIL full_slot%0d: got data=%h np=%b busy=%b full5=%b, want %h/%b/%b/%b", s, DataOut, NewPacket, Busy, Full[5], tbl[s][10:3], tbl[s][2], tbl[s][1], tbl[s][0]);
            end
        end
    endtask

    task automatic test_inflight();
        logic [9:0] tbl [7];
        tbl = '{{8'h00, 2'b00}, {8'h41, 2'b11}, {8'hB1, 2'b01}, {8'h00, 2'b00},
                {8'h41, 2'b11}, {8'hB2, 2'b01}, {8'h00, 2'b00}};
        for (int s = 0; s < 7; s++) begin
            clearInputs();
            if (s == 0) begin wr[4] = 1'b1; din[4] = 8'hB1; end
            if (s == 2) begin wr[4] = 1'b1; din[4] = 8'hB2; end
            step();
            checks++;
            if ({DataOut, NewPacket, Busy} !== tbl[s]) begin
                errors++;
                $display("[TB] FAIL inflight_slot%0d: got data=%h np=%b busy=%b, want %h/%b/%b", s, DataOut, NewPacket, Busy, tbl[s][9:2], tbl[s][1], tbl[s][0]);
            end
        end
    endtask

    task automatic test_alternate();
        int hdrCount;
        int wantChan;
        bit done;
        hdrCount = 0;
        for (int s = 0; s < 40; s++) begin
            clearInputs();
            wr = 8'b0000_0110;
            din[1] = 8'($urandom);
            din[2] = 8'($urandom);
            step();
            checks++;
            if ({DataOut, NewPacket, Busy, Full} !== {expData, expNew, expBusy, expFull()}) begin
                errors++;
                $display("[TB] FAIL alt_cycle%0d: got %h/%b/%b/%b, want %h/%b/%b/%b", s, DataOut, NewPacket, Busy, Full, expData, expNew, expBusy, expFull());
            end
            if (NewPacket === 1'b1) begin
`ifdef SERIAL_MUX_FIXED_PRIORITY_EN
                wantChan = 1;
`else
                wantChan = (hdrCount % 2 == 0) ? 1 : 2;
`endif
                checks++;
                if (int'(DataOut[6:4]) != wantChan) begin
                    errors++;
                    $display("[TB] FAIL alt_header%0d: got channel %0d, want %0d", hdrCount, DataOut[6:4], wantChan);
                end
                hdrCount++;
            end
        end
        checks++;
        if (hdrCount < 4) begin
            errors++;
            $display("[TB] FAIL alt_header_count: got %0d headers, want at least 4", hdrCount);
        end
        clearInputs();
        done = 0;
        for (int s = 0; s < 60 && !done; s++) begin
            step();
            checks++;
            if ({DataOut, NewPacket, Busy, Full} !== {expData, expNew, expBusy, expFull()}) begin
                errors++;
                $display("[TB] FAIL alt_drain%0d: got %h/%b/%b/%b, want %h/%b/%b/%b", s, DataOut, NewPacket, Busy, Full, expData, expNew, expBusy, expFull());
            end
            done = modelQuiet();
        end
        checks++;
        if (!done) begin
            errors++;
            $display("[TB] FAIL alt_drain_timeout: got busy after 60 cycles, want idle");
        end
    endtask

    task automatic test_random();
        bit done;
        for (int s = 0; s < 300; s++) begin
            wr = 8'($urandom) & 8'($urandom);
            for (int i = 0; i < 8; i++) din[i] = 8'($urandom);
            step();
            checks++;
            if ({DataOut, NewPacket, Busy, Full} !== {expData, expNew, expBusy, expFull()}) begin
                errors++;
                $display("[TB] FAIL random_cycle%0d: got %h/%b/%b/%b, want %h/%b/%b/%b", s, DataOut, NewPacket, Busy, Full, expData, expNew, expBusy, expFull());
            end
        end
        clearInputs();
        done = 0;
        for (int s = 0; s < 200 && !done; s++) begin
            step();
            checks++;
            if ({DataOut, NewPacket, Busy, Full} !== {expData, expNew, expBusy, expFull()}) begin
                errors++;
                $display("[TB] FAIL random_drain%0d: got %h/%b/%b/%b, want %h/%b/%b/%b", s, DataOut, NewPacket, Busy, Full, expData, expNew, expBusy, expFull());
            end
            done = modelQuiet();
        end
        checks++;
        if (!done) begin
            errors++;
            $display("[TB] FAIL random_drain_timeout: got busy after 200 cycles, want idle");
        end
    endtask

    task automatic test_reset_midpacket();
        logic [9:0] tbl [7];
        bit done;
        tbl = '{{8'h00, 2'b00}, {8'h11, 2'b11}, {8'hD0, 2'b01}, {8'h00, 2'b00},
                {8'h23, 2'b11}, {8'hC1, 2'b01}, {8'hC2, 2'b01}};
        clearInputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int s = 0; s < 7; s++) begin
            clearInputs();
            if (s == 0) begin wr[1] = 1'b1; din[1] = 8'hD0; end
            if (s < 3) begin wr[2] = 1'b1; din[2] = 8'hC1 + 8'(s); end
            if (s < 4) begin wr[5] = 1'b1; din[5] = 8'h50 + 8'(s); end
            step();
            checks++;
            if ({DataOut, NewPacket, Busy} !== tbl[s]) begin
                errors++;
                $display("[TB] FAIL rstmid_slot%0d: got data=%h np=%b busy=%b, want %h/%b/%b", s, DataOut, NewPacket, Busy, tbl[s][9:2], tbl[s][1], tbl[s][0]);
            end
        end
        checks++;
        if (Full !== 8'h20) begin
            errors++;
            $display("[TB] FAIL rstmid_full_before: got %b, want 00100000", Full);
        end
        clearInputs();
        #2 rst = 1'b1;
        #1;
        modelReset();
        checks++;
        if ({DataOut, NewPacket, Busy, Full} !== 18'h0) begin
            errors++;
            $display("[TB] FAIL rstmid_async: got data=%h np=%b busy=%b full=%b, want all zero", DataOut, NewPacket, Busy, Full);
        end
        step();
        #2 rst = 1'b0;
        for (int s = 0; s < 8; s++) begin
            step();
            checks++;
            if ({DataOut, NewPacket, Busy, Full} !== 18'h0) begin
                errors++;
                $display("[TB] FAIL rstmid_quiet%0d: got data=%h np=%b busy=%b full=%b, want all zero", s, DataOut, NewPacket, Busy, Full);
            end
        end
        wr[0] = 1'b1; din[0] = 8'hE0;
        wr[3] = 1'b1; din[3] = 8'hE3;
        step();
        clearInputs();
        step();
        checks++;
        if ({DataOut, NewPacket, Busy} !== {8'h01, 2'b11}) begin
            errors++;
            $display("[TB] FAIL rstmid_first_header: got data=%h np=%b busy=%b, want 01/1/1", DataOut, NewPacket, Busy);
        end
        done = 0;
        for (int s = 0; s < 30 && !done; s++) begin
            step();
            checks++;
            if ({DataOut, NewPacket, Busy, Full} !== {expData, expNew, expBusy, expFull()}) begin
                errors++;
                $display("[TB] FAIL rstmid_drain%0d: got %h/%b/%b/%b, want %h/%b/%b/%b", s, DataOut, NewPacket, Busy, Full, expData, expNew, expBusy, expFull());
            end
            done = modelQuiet();
        end
        checks++;
        if (!done) begin
            errors++;
            $display("[TB] FAIL rstmid_drain_timeout: got busy after 30 cycles, want idle");
        end
    endtask

    initial begin
        test_reset();
        test_channel7();
        test_roundrobin();
        test_full();
        test_inflight();
        test_alternate();
        test_random();
        test_reset_midpacket();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
